// File: rtl/fft_bank_scheduler_pkg.sv
// Shared defaults and write-side state encodings for the FFT ping-pong bank scheduler
// and the display front-end that reads from it.
package fft_bank_scheduler_pkg;

   localparam int N_POINTS_DEF = 512;
   localparam int DW_DEF       = 9;
   localparam int AW_DEF       = 9;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_FILL = 2'd1,
      W_HOLD = 2'd2
   } wr_state_t;

endpackage

// File: rtl/fft_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks, addressed as {bank, ptr}.
// The read port is registered and read-before-write on an address collision.
module fft_bank_ram #(
   parameter int DW = 9,
   parameter int AW = 9
) (
   input  logic          pclk,
   input  logic          wr_en,
   input  logic [AW:0]   wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW:0]   rd_addr,
   output logic [DW-1:0] rd_q
);

   logic [DW-1:0] mem [0:(1<<(AW+1))-1];

   always_ff @(posedge pclk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_q <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/fft_bank_scheduler.sv
// Ping-pong buffering of FFT magnitude frames: fills one bank while the display reads the
// other, committing a complete frame only on a vs rising edge and counting discarded frames.
module fft_bank_scheduler
   import fft_bank_scheduler_pkg::*;
#(
   parameter int N_POINTS = N_POINTS_DEF,
   parameter int DW       = DW_DEF,
   parameter int AW       = AW_DEF
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          fft_valid,
   input  logic [DW-1:0] fft_data,
   input  logic          fft_eop,
   input  logic          vs,
   input  logic          data_req,
   input  logic          line_done,
   output logic [DW-1:0] rd_data,
   output logic [AW-1:0] rd_cnt,
   output logic          frame_swap,
   output logic          disp_valid,
   output logic [7:0]    drop_cnt
);

   localparam logic [AW:0]   FULL    = (AW+1)'(N_POINTS);
   localparam logic [AW:0]   LAST    = (AW+1)'(N_POINTS-1);
   localparam logic [AW-1:0] RD_LAST = AW'(N_POINTS-1);

   wr_state_t     state, state_nx;
   logic          wr_bank, wr_bank_nx;
   logic [AW:0]   wr_ptr, wr_ptr_nx;
   logic          vs_d, vs_rise, swap;
   logic [1:0]    drop_inc;
   logic [8:0]    drop_sum;
   logic          wr_en;
   logic [AW:0]   wr_addr;
   logic [DW-1:0] ram_q;
   logic          rd_loaded;

   assign vs_rise  = vs & ~vs_d;
   assign drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};

   // wr_ptr saturates at FULL so overrun samples are dropped; only an eop landing
   // exactly on the last point completes a frame. A 1-sample frame counts as a drop.
   always_comb begin
      state_nx   = state;
      wr_bank_nx = wr_bank;
      wr_ptr_nx  = wr_ptr;
      drop_inc   = 2'd0;
      swap       = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = {wr_bank, wr_ptr[AW-1:0]};
      case (state)
         W_FILL: begin
            if (fft_valid) begin
               if (wr_ptr != FULL) begin
                  wr_en     = 1'b1;
                  wr_ptr_nx = wr_ptr + 1'b1;
               end
               if (fft_eop) begin
                  wr_ptr_nx = '0;
                  if (wr_ptr == LAST) begin
                     state_nx = W_HOLD;
                  end else begin
                     drop_inc = 2'd1;
                     state_nx = W_IDLE;
                  end
               end
            end
         end
         W_HOLD: begin
            if (vs_rise) begin
               swap       = 1'b1;
               wr_bank_nx = ~wr_bank;
               state_nx   = W_IDLE;
            end
            if (fft_valid) begin
               if (!vs_rise) begin
                  drop_inc = 2'd1;
               end
               wr_en     = 1'b1;
               wr_addr   = {wr_bank_nx, {AW{1'b0}}};
               wr_ptr_nx = {{AW{1'b0}}, 1'b1};
               state_nx  = W_FILL;
               if (fft_eop) begin
                  drop_inc  = drop_inc + 2'd1;
                  wr_ptr_nx = '0;
                  state_nx  = W_IDLE;
               end
            end
         end
         default: begin
            if (fft_valid) begin
               wr_en     = 1'b1;
               wr_addr   = {wr_bank, {AW{1'b0}}};
               wr_ptr_nx = {{AW{1'b0}}, 1'b1};
               state_nx  = W_FILL;
               if (fft_eop) begin
                  drop_inc  = 2'd1;
                  wr_ptr_nx = '0;
                  state_nx  = W_IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state      <= W_IDLE;
         wr_bank    <= 1'b0;
         wr_ptr     <= '0;
         vs_d       <= 1'b0;
         frame_swap <= 1'b0;
         disp_valid <= 1'b0;
         drop_cnt   <= 8'd0;
      end else begin
         state      <= state_nx;
         wr_bank    <= wr_bank_nx;
         wr_ptr     <= wr_ptr_nx;
         vs_d       <= vs;
         frame_swap <= swap;
         if (swap) begin
            disp_valid <= 1'b1;
         end
         drop_cnt   <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

   // rd_loaded keeps stale or uninitialised RAM output hidden until a read of a committed bank
   always_ff @(posedge pclk) begin
      if (rst) begin
         rd_cnt    <= '0;
         rd_loaded <= 1'b0;
      end else begin
         if (data_req && disp_valid) begin
            rd_loaded <= 1'b1;
         end
         if (line_done) begin
            rd_cnt <= '0;
         end else if (data_req && rd_cnt != RD_LAST) begin
            rd_cnt <= rd_cnt + 1'b1;
         end
      end
   end

   assign rd_data = (disp_valid && rd_loaded) ? ram_q : '0;

   fft_bank_ram #(
      .DW (DW),
      .AW (AW)
   ) u_ram (
      .pclk    (pclk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (fft_data),
      .rd_en   (data_req),
      .rd_addr ({~wr_bank, rd_cnt}),
      .rd_q    (ram_q)
   );

endmodule

// File: tb/tb_fft_bank_scheduler.sv
// Self-checking bench for fft_bank_scheduler: a vector table, directed frame scenarios and
// randomized traffic, all compared every cycle against a frame-level reference model.
module tb_fft_bank_scheduler;

   localparam int N  = 512;
   localparam int DW = 9;
   localparam int AW = 9;

   logic          pclk = 1'b0;
   logic          rst, fft_valid, fft_eop, vs, data_req, line_done;
   logic [DW-1:0] fft_data;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] rd_cnt;
   logic          frame_swap, disp_valid;
   logic [7:0]    drop_cnt;

   int checks   = 0;
   int failures = 0;

   int m_disp [N];
   int m_pend [N];
   int m_cur  [N];
   int m_cnt, m_drop, m_rd_cnt, m_rd_data;
   bit m_pending, m_disp_valid, m_swap, m_vs_prev;

   typedef struct {
      bit dreq;
      bit ldone;
      bit vsync;
      int exp_rd_cnt;
      bit exp_disp_valid;
      bit exp_swap;
   } vec_t;

   vec_t vecs [10];

   always #5 pclk = ~pclk;

   fft_bank_scheduler #(.N_POINTS(N), .DW(DW), .AW(AW)) dut (
      .pclk       (pclk),
      .rst        (rst),
      .fft_valid  (fft_valid),
      .fft_data   (fft_data),
      .fft_eop    (fft_eop),
      .vs         (vs),
      .data_req   (data_req),
      .line_done  (line_done),
      .rd_data    (rd_data),
      .rd_cnt     (rd_cnt),
      .frame_swap (frame_swap),
      .disp_valid (disp_valid),
      .drop_cnt   (drop_cnt)
   );

   task automatic checkVal(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bumpDrop();
      if (m_drop < 255) m_drop++;
   endtask

   // Frame-level behaviour: a frame is committed only if exactly N samples end in eop,
   // and it is shown only after a vs rising edge; anything else is a discarded frame.
   task automatic modelUpdate();
      bit vs_rise;
      if (rst) begin
         m_cnt = 0; m_drop = 0; m_rd_cnt = 0; m_rd_data = 0;
         m_pending = 0; m_disp_valid = 0; m_swap = 0; m_vs_prev = 0;
         return;
      end
      m_swap = 0;
      if (data_req && m_disp_valid) m_rd_data = m_disp[m_rd_cnt];
      if (line_done) m_rd_cnt = 0;
      else if (data_req && m_rd_cnt < N-1) m_rd_cnt++;
      vs_rise   = vs && !m_vs_prev;
      m_vs_prev = vs;
      if (m_pending && vs_rise) begin
         m_disp = m_pend;
         m_disp_valid = 1;
         m_swap = 1;
         m_pending = 0;
      end
      if (fft_valid) begin
         if (m_pending) begin
            bumpDrop();
            m_pending = 0;
         end
         if (m_cnt < N) m_cur[m_cnt] = int'(fft_data);
         m_cnt++;
         if (fft_eop) begin
            if (m_cnt == N) begin
               m_pending = 1;
               m_pend = m_cur;
            end else begin
               bumpDrop();
            end
            m_cnt = 0;
         end
      end
   endtask

   task automatic checkOutput();
      checkVal("rd_data",    int'(rd_data),    m_rd_data);
      checkVal("rd_cnt",     int'(rd_cnt),     m_rd_cnt);
      checkVal("frame_swap", int'(frame_swap), int'(m_swap));
      checkVal("disp_valid", int'(disp_valid), int'(m_disp_valid));
      checkVal("drop_cnt",   int'(drop_cnt),   m_drop);
   endtask

   // Inputs change on the falling edge; the model steps on the rising edge.
   task automatic applyStimulus();
      @(posedge pclk);
      modelUpdate();
      @(negedge pclk);
      checkOutput();
   endtask

   task automatic idleInputs();
      rst = 0; fft_valid = 0; fft_eop = 0; fft_data = '0;
      vs = 0; data_req = 0; line_done = 0;
   endtask

   task automatic doReset();
      idleInputs();
      rst = 1;
      applyStimulus();
      applyStimulus();
      rst = 0;
   endtask

   // mode 0: data = index, 1: data = cval, 2: data = N-1-index
   task automatic sendFrame(input int len, input int mode, input int cval, input bit vsFirst);
      for (int i = 0; i < len; i++) begin
         fft_valid = 1;
         fft_eop   = (i == len-1);
         vs        = vsFirst && (i == 0);
         case (mode)
            0:       fft_data = DW'(i);
            1:       fft_data = DW'(cval);
            default: fft_data = DW'(N-1-i);
         endcase
         applyStimulus();
      end
      fft_valid = 0; fft_eop = 0; vs = 0;
   endtask

   task automatic vsPulse();
      vs = 1;
      applyStimulus();
      checkVal("swap_on_vs", int'(frame_swap), int'(m_swap));
      vs = 0;
      applyStimulus();
   endtask

   task automatic rewind();
      line_done = 1;
      applyStimulus();
      line_done = 0;
   endtask

   initial begin
      vecs[0] = '{1, 0, 0, 1, 0, 0};
      vecs[1] = '{1, 0, 0, 2, 0, 0};
      vecs[2] = '{0, 0, 0, 2, 0, 0};
      vecs[3] = '{0, 1, 0, 0, 0, 0};
      vecs[4] = '{1, 0, 0, 1, 0, 0};
      vecs[5] = '{1, 1, 0, 0, 0, 0};
      vecs[6] = '{0, 0, 1, 0, 0, 0};
      vecs[7] = '{1, 0, 1, 1, 0, 0};
      vecs[8] = '{0, 0, 0, 1, 0, 0};
      vecs[9] = '{0, 1, 0, 0, 0, 0};

      idleInputs();
      @(negedge pclk);
      doReset();
      checkVal("reset_rd_cnt", int'(rd_cnt), 0);
      checkVal("reset_rd_data", int'(rd_data), 0);
      checkVal("reset_disp_valid", int'(disp_valid), 0);
      checkVal("reset_drop", int'(drop_cnt), 0);

      $display("[TB] vector table, no frame loaded");
      for (int i = 0; i < 10; i++) begin
         data_req = vecs[i].dreq; line_done = vecs[i].ldone; vs = vecs[i].vsync;
         applyStimulus();
         checkVal("vec_rd_cnt", int'(rd_cnt), vecs[i].exp_rd_cnt);
         checkVal("vec_disp_valid", int'(disp_valid), int'(vecs[i].exp_disp_valid));
         checkVal("vec_swap", int'(frame_swap), int'(vecs[i].exp_swap));
         checkVal("vec_rd_data", int'(rd_data), 0);
      end
      idleInputs();

      $display("[TB] full frame, swap and readback");
      doReset();
      sendFrame(N, 0, 0, 0);
      checkVal("a_no_early_swap", int'(disp_valid), 0);
      vs = 1;
      applyStimulus();
      checkVal("a_swap_pulse", int'(frame_swap), 1);
      checkVal("a_disp_valid", int'(disp_valid), 1);
      applyStimulus();
      checkVal("a_swap_single", int'(frame_swap), 0);
      vs = 0;
      for (int i = 0; i < N; i++) begin
         data_req = 1;
         applyStimulus();
         checkVal("a_read", int'(rd_data), i);
      end
      data_req = 0;

      $display("[TB] read pointer overrun then line_done with data_req");
      rewind();
      data_req = 1;
      for (int i = 0; i < 600; i++) applyStimulus();
      checkVal("e_rd_cnt_sat", int'(rd_cnt), N-1);
      line_done = 1;
      applyStimulus();
      checkVal("e_last_read", int'(rd_data), N-1);
      checkVal("e_rd_cnt_zero", int'(rd_cnt), 0);
      idleInputs();

      $display("[TB] short frame is discarded");
      doReset();
      sendFrame(300, 0, 0, 0);
      checkVal("b_drop", int'(drop_cnt), 1);
      vsPulse();
      checkVal("b_no_swap", int'(disp_valid), 0);

      $display("[TB] pending frame overwritten");
      doReset();
      sendFrame(N, 1, 5, 0);
      sendFrame(N, 1, 9, 0);
      vsPulse();
      checkVal("c_drop", int'(drop_cnt), 1);
      data_req = 1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkVal("c_read", int'(rd_data), 9);
      end
      data_req = 0;

      $display("[TB] vs edge together with first sample in hold");
      doReset();
      sendFrame(N, 0, 0, 0);
      sendFrame(N, 2, 0, 1);
      checkVal("d_drop", int'(drop_cnt), 0);
      checkVal("d_disp_valid", int'(disp_valid), 1);
      rewind();
      data_req = 1;
      applyStimulus();
      data_req = 0;
      checkVal("d_old_frame", int'(rd_data), 0);
      vsPulse();
      rewind();
      data_req = 1;
      applyStimulus();
      data_req = 0;
      checkVal("d_new_frame", int'(rd_data), N-1);

      $display("[TB] reset in the middle of a frame");
      doReset();
      sendFrame(200, 1, 7, 0);
      fft_valid = 1; fft_data = DW'(7); rst = 1;
      applyStimulus();
      idleInputs();
      applyStimulus();
      sendFrame(N, 0, 0, 0);
      vsPulse();
      checkVal("f_drop", int'(drop_cnt), 0);
      data_req = 1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus();
         checkVal("f_read", int'(rd_data), i);
      end
      idleInputs();

      $display("[TB] randomized traffic");
      doReset();
      for (int f = 0; f < 14; f++) begin
         int len, sel, gap;
         sel = $urandom_range(0, 5);
         case (sel)
            0, 1, 2: len = N;
            3:       len = 300;
            4:       len = N + 3;
            default: len = 20;
         endcase
         for (int i = 0; i < len; i++) begin
            do begin
               fft_valid = ($urandom_range(0, 7) != 0);
               fft_data  = DW'($urandom_range(0, N-1));
               fft_eop   = fft_valid && (i == len-1);
               vs        = ($urandom_range(0, 15) == 0);
               data_req  = $urandom_range(0, 1);
               line_done = ($urandom_range(0, 49) == 0);
               applyStimulus();
            end while (!fft_valid);
         end
         gap = $urandom_range(0, 40);
         fft_valid = 0; fft_eop = 0;
         for (int g = 0; g < gap; g++) begin
            vs        = ($urandom_range(0, 3) == 0);
            data_req  = $urandom_range(0, 1);
            line_done = ($urandom_range(0, 49) == 0);
            applyStimulus();
         end
      end
      idleInputs();
      applyStimulus();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fft_bank_scheduler.md
FFT_BANK_SCHEDULER -- requirements
Module: fft_bank_scheduler

Interface
REQ-001 Parameter: N_POINTS, default 512, number of spectrum points per FFT frame (power of two).
REQ-002 Parameter: DW, default 9, magnitude data width.
REQ-003 Parameter: AW, default 9, point address width, equal to log2(N_POINTS).
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 pclk  in  1  Pixel clock; all logic on the rising edge.
REQ-006 rst  in  1  Synchronous active-high reset.
REQ-007 fft_valid  in  1  Magnitude sample strobe.
REQ-008 fft_data  in  DW  Magnitude sample.
REQ-009 fft_eop  in  1  Last-sample marker; qualified by fft_valid.
REQ-010 vs  in  1  Display frame sync, high active; the rising edge is the swap point.
REQ-011 data_req  in  1  Read-next-point request from the display.
REQ-012 line_done  in  1  End-of-line pulse; rewinds the read pointer.
REQ-013 rd_data  out  DW  Magnitude of the requested point.
REQ-014 rd_cnt  out  AW  Point index currently addressed (display x-slot).
REQ-015 frame_swap  out  1  One-cycle pulse on each bank swap.
REQ-016 disp_valid  out  1  High once a complete frame has been swapped in.
REQ-017 drop_cnt  out  8  Count of discarded frames, saturating.

Function
REQ-018 Storage: two banks of N_POINTS x DW, used as ping-pong buffers; wr_bank is the fill bank and the display reads !wr_bank.
REQ-019 Write FSM states: W_IDLE, W_FILL, W_HOLD.
REQ-020 W_IDLE on fft_valid: write point 0 to the fill bank, set wr_ptr to 1, go to W_FILL.
REQ-021 W_FILL on fft_valid: write at wr_ptr, then increment wr_ptr.
REQ-022 W_FILL on fft_valid&fft_eop with exactly N_POINTS points written: go to W_HOLD.
REQ-023 W_FILL on eop with fewer than N_POINTS points: discard the frame, increment drop_cnt, go to W_IDLE.
REQ-024 W_FILL overrun: samples beyond N_POINTS before eop are not written; on eop, discard the frame and increment drop_cnt.
REQ-025 W_HOLD on the vs rising edge: toggle wr_bank, pulse frame_swap, set disp_valid, go to W_IDLE.
REQ-026 W_HOLD on fft_valid with no vs edge: the pending frame is overwritten; increment drop_cnt, write point 0, go to W_FILL.
REQ-027 Simultaneous vs edge and fft_valid in W_HOLD: the swap takes effect first; the sample is written as point 0 of the new fill bank; state becomes W_FILL; drop_cnt is unchanged.
REQ-028 A vs edge in W_IDLE or W_FILL causes no swap, and the display keeps its current bank.
REQ-029 Read side: on data_req, read from bank !wr_bank at rd_cnt, then increment rd_cnt.
REQ-030 rd_cnt saturates at N_POINTS-1 and does not wrap.
REQ-031 rd_data is registered and is valid 1 cycle after data_req; it holds its value between requests.
REQ-032 line_done sets rd_cnt to 0.
REQ-033 line_done together with data_req: the read uses the old rd_cnt, and rd_cnt then becomes 0.
REQ-034 While disp_valid=0, rd_data reads as 0.
REQ-035 The vs edge detector compares vs with its 1-cycle delayed copy.
REQ-036 A swap occurring during a line takes effect on the next read, so the display always reads the committed bank.
REQ-037 drop_cnt saturates at 255.

Reset
REQ-038 On rst: state=W_IDLE, wr_bank=0, wr_ptr=0, rd_cnt=0, rd_data=0, frame_swap=0, disp_valid=0, drop_cnt=0, vs delay=0.
REQ-039 RAM contents are not reset.
REQ-040 Reset mid-frame: the partial frame is lost and is not counted in drop_cnt.
REQ-041 rst has priority over all other inputs in the same cycle.

Structure
REQ-042 Shared package holds N_POINTS, DW, AW defaults and the write-state encodings, for reuse by the display front-end.
REQ-043 Sub-module fft_bank_ram: simple dual-port 2*N_POINTS x DW RAM with address {bank, ptr}, one write port, and one registered read port.
REQ-044 Target RTL size: 120-400 lines total.

Verification
REQ-045 Reset, then 512 valid samples with fft_data=index and eop on the last, then a vs rising edge -> frame_swap pulses once, disp_valid=1, and 512 data_req reads return 0..511 at 1-cycle latency.
REQ-046 A 300-sample frame ending in eop -> drop_cnt=1, state W_IDLE, no swap on the following vs.
REQ-047 Two full frames (A=5, B=9) with no vs between them, then vs -> drop_cnt=1 and reads return 9.
REQ-048 vs edge in the same cycle as the first valid of a new frame while in W_HOLD -> swap occurs, drop_cnt=0, the new sample lands at point 0 of the other bank, and the next swap displays it.
REQ-049 600 data_req pulses, then line_done together with data_req -> rd_cnt stays at 511 through the overrun, the last read returns point 511, and rd_cnt then becomes 0.
REQ-050 rst asserted at sample 200 of a frame, then one clean full frame and vs -> reads return only clean-frame data and drop_cnt=0.
